// File: rtl/datapath_pipe.sv
// -----------------------------------------------------------------------------
// datapath_pipe
//   Two-stage register-file + ALU datapath.
//     OF : reads operands A/B from the register file, selects B and the memory
//          address, and loads them into the EX register when an instruction
//          is accepted.
//     EX : computes the ALU result, or waits for load data, then writes back
//          into the register file and updates the status flags.
//
//   Handshake: an instruction is accepted on a rising edge where
//   in_valid & in_ready are both 1. in_valid may be raised at any time and
//   must hold its fields stable until accepted. in_ready is computed from the
//   EX state and the incoming source fields. It does not depend on in_valid.
//   EX releases its slot when ex_done = exValid & (!exMd | mem_valid).
//
//   Build option DATAPATH_FWD_EN:
//     defined   - the writeback value is bypassed into the OF operand mux.
//                 A dependent instruction is accepted back-to-back.
//     undefined - a read-after-write hazard against EX drops in_ready. The
//                 instruction enters OF the cycle after retire and reads the
//                 register file normally.
//
// Parameters: DW datapath width, NREG registers, AW address/PC width.
// Ports:
//   clk_main, reset (sync, active-low)
//   in_valid / in_ready            instruction handshake
//   DR, SA, SB, FS, MB, MM, MD, RW decoded instruction fields
//   const_in, PC                   immediate operand, program counter
//   mem_rdata, mem_valid           load data return
//   BusA, DataOut, AddrOut         EX-stage operands / memory address
//   Z, N, C, V                     flags of the last retired ALU operation
// -----------------------------------------------------------------------------
module datapath_pipe #(
  parameter int DW   = 16,
  parameter int NREG = 16,
  parameter int AW   = 6,
  localparam int RA  = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic          clk_main,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [RA-1:0] DR,
  input  logic [RA-1:0] SA,
  input  logic [RA-1:0] SB,
  input  logic [3:0]    FS,
  input  logic          MB,
  input  logic          MM,
  input  logic          MD,
  input  logic          RW,
  input  logic [DW-1:0] const_in,
  input  logic [AW-1:0] PC,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_valid,
  output logic [DW-1:0] BusA,
  output logic [DW-1:0] DataOut,
  output logic [AW-1:0] AddrOut,
  output logic          Z,
  output logic          N,
  output logic          C,
  output logic          V
);

  logic [DW-1:0] regs [NREG];

  // EX-stage control captured at accept
  logic          exValid;
  logic [RA-1:0] exDr;
  logic [3:0]    exFs;
  logic          exMd;
  logic          exRw;

  logic          exDone;
  logic          fire;
  logic          hazard;
  logic [DW-1:0] wbVal;
  logic [DW-1:0] opA;
  logic [DW-1:0] regB;
  logic [DW-1:0] opB;

  // ALU
  logic [DW-1:0] aluF;
  logic [DW-1:0] addB;
  logic          addCin;
  logic          isArith;
  logic [DW:0]   addSum;
  logic          aluC;
  logic          aluV;

  always_comb begin
    addB    = '0;
    addCin  = 1'b0;
    isArith = 1'b0;
    aluF    = BusA;
    case (exFs)
      4'h1: begin addCin = 1'b1;                      isArith = 1'b1; end
      4'h2: begin addB = DataOut;                     isArith = 1'b1; end
      4'h3: begin addB = DataOut;  addCin = 1'b1;     isArith = 1'b1; end
      4'h4: begin addB = ~DataOut;                    isArith = 1'b1; end
      4'h5: begin addB = ~DataOut; addCin = 1'b1;     isArith = 1'b1; end
      4'h6: begin addB = '1;                          isArith = 1'b1; end
      4'h8: aluF = BusA & DataOut;
      4'h9: aluF = BusA | DataOut;
      4'hA: aluF = BusA ^ DataOut;
      4'hB: aluF = ~BusA;
      4'hC: aluF = DataOut;
      4'hD: aluF = DataOut >> 1;
      4'hE: aluF = DataOut << 1;
      4'hF: aluF = DataOut;
      default: aluF = BusA;   // 0 and 7 pass A
    endcase
    // Every arithmetic op is A + addB + addCin; subtraction uses ~B + 1.
    addSum = {1'b0, BusA} + {1'b0, addB} + {{DW{1'b0}}, addCin};
    if (isArith) aluF = addSum[DW-1:0];
    aluC = isArith & addSum[DW];
    // Overflow: both addends share a sign that the result does not.
    aluV = isArith & (BusA[DW-1] == addB[DW-1]) & (aluF[DW-1] != BusA[DW-1]);
  end

  assign exDone = exValid & (~exMd | mem_valid);
  assign wbVal  = exMd ? mem_rdata : aluF;

`ifdef DATAPATH_FWD_EN
  assign opA    = (exDone & exRw & (exDr == SA)) ? wbVal : regs[SA];
  assign regB   = (exDone & exRw & (exDr == SB)) ? wbVal : regs[SB];
  assign hazard = 1'b0;
`else
  assign opA    = regs[SA];
  assign regB   = regs[SB];
  assign hazard = exValid & exRw & ((exDr == SA) | (~MB & (exDr == SB)));
`endif

  assign opB      = MB ? const_in : regB;
  assign in_ready = reset & (~exValid | exDone) & ~hazard;
  assign fire     = in_valid & in_ready;

  always_ff @(posedge clk_main) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      exValid <= 1'b0;
      exDr    <= '0;
      exFs    <= '0;
      exMd    <= 1'b0;
      exRw    <= 1'b0;
      BusA    <= '0;
      DataOut <= '0;
      AddrOut <= '0;
      Z       <= 1'b0;
      N       <= 1'b0;
      C       <= 1'b0;
      V       <= 1'b0;
    end else begin
      if (exDone) begin
        if (exRw) regs[exDr] <= wbVal;
        // Loads retire without touching the flags.
        if (!exMd) begin
          Z <= (aluF == '0);
          N <= aluF[DW-1];
          C <= aluC;
          V <= aluV;
        end
      end
      if (fire) begin
        exValid <= 1'b1;
        exDr    <= DR;
        exFs    <= FS;
        exMd    <= MD;
        exRw    <= RW;
        BusA    <= opA;
        DataOut <= opB;
        AddrOut <= MM ? PC : opA[AW-1:0];
      end else if (exDone) begin
        // Operand outputs hold their last value while EX is empty.
        exValid <= 1'b0;
      end
    end
  end

endmodule
